// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers build the window, Gx/Gy are thresholded into binary edge maps.
// Latency: a result appears 3 cycles after the pixel that completes its window (S1 window, S2 gradients, S3 compare).
// Backpressure: none; every valid pixel is accepted and stages advance every cycle regardless of i_in_valid.
// Ports: i_clk/i_reset (sync, active-high), i_in_valid/i_in_pixel (raster stream), i_threshold/i_mode (latched at pixel (0,0)),
//        o_out_valid (one pulse per interior pixel), o_out_x/o_out_y (8'd255 on edge), o_out_last (last interior pixel of frame).
module sobel_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int TH_W  = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    input  logic [PIX_W-1:0] i_in_pixel,
    input  logic [TH_W-1:0]  i_threshold,
    input  logic [1:0]       i_mode,
    output logic             o_out_valid,
    output logic [7:0]       o_out_x,
    output logic [7:0]       o_out_y,
    output logic             o_out_last
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int G_W   = PIX_W + 3;   // signed gradient width, never overflows
    localparam int S_W   = PIX_W + 4;   // |Gx|+|Gy| width
    localparam int C_W   = TH_W + 1;    // common signed compare width

    // ---------------- position counters ----------------
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_first;
    logic             w_win_full;

    assign w_col_end  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_end  = (r_row == ROW_W'(IMG_H - 1));
    assign w_first    = (r_col == '0) && (r_row == '0);
    // col>=2 also keeps the window from straddling a line wrap
    assign w_win_full = (r_col >= COL_W'(2)) && (r_row >= ROW_W'(2));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_in_valid) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // ---------------- per-frame threshold / mode ----------------
    logic signed [TH_W-1:0] r_th;
    logic [1:0]             r_mode;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_th   <= '0;
            r_mode <= '0;
        end else if (i_in_valid && w_first) begin
            r_th   <= i_threshold;
            r_mode <= i_mode;
        end
    end

    // ---------------- line buffers (contents need no reset) ----------------
    logic [PIX_W-1:0] r_lb0 [0:IMG_W-1];   // row r-1
    logic [PIX_W-1:0] r_lb1 [0:IMG_W-1];   // row r-2
    logic [PIX_W-1:0] w_lb0_rd;
    logic [PIX_W-1:0] w_lb1_rd;

    assign w_lb0_rd = r_lb0[r_col];
    assign w_lb1_rd = r_lb1[r_col];

    always_ff @(posedge i_clk) begin
        if (i_in_valid) begin
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= i_in_pixel;
        end
    end

    // ---------------- S1: window register ----------------
    logic [PIX_W-1:0]       r_win [0:8];
    logic                   r_s1_vld;
    logic                   r_s1_last;
    logic signed [TH_W-1:0] r_s1_th;
    logic [1:0]             r_s1_mode;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_th   <= '0;
            r_s1_mode <= '0;
        end else begin
            r_s1_vld  <= i_in_valid && w_win_full;
            r_s1_last <= i_in_valid && w_col_end && w_row_end;
            // interior pixels are never (0,0), so the frame copy is already current
            r_s1_th   <= r_th;
            r_s1_mode <= r_mode;
            if (i_in_valid) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb1_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb0_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= i_in_pixel;
            end
        end
    end

    // ---------------- S2: gradients ----------------
    logic signed [G_W-1:0] w_p [0:8];
    logic signed [G_W-1:0] w_gx;
    logic signed [G_W-1:0] w_gy;

    always_comb begin
        for (int i = 0; i < 9; i++) w_p[i] = $signed({3'b000, r_win[i]});
    end

    assign w_gx = (w_p[2] - w_p[0]) + ((w_p[5] - w_p[3]) <<< 1) + (w_p[8] - w_p[6]);
    assign w_gy = (w_p[0] - w_p[6]) + ((w_p[1] - w_p[7]) <<< 1) + (w_p[2] - w_p[8]);

    logic signed [G_W-1:0]  r_s2_gx;
    logic signed [G_W-1:0]  r_s2_gy;
    logic                   r_s2_vld;
    logic                   r_s2_last;
    logic signed [TH_W-1:0] r_s2_th;
    logic [1:0]             r_s2_mode;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s2_gx   <= '0;
            r_s2_gy   <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_th   <= '0;
            r_s2_mode <= '0;
        end else begin
            r_s2_gx   <= w_gx;
            r_s2_gy   <= w_gy;
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last && r_s1_vld;
            r_s2_th   <= r_s1_th;
            r_s2_mode <= r_s1_mode;
        end
    end

    // ---------------- S3: threshold compare ----------------
    logic [G_W-1:0]        w_gx_abs;
    logic [G_W-1:0]        w_gy_abs;
    logic [S_W-1:0]        w_sum;
    logic signed [C_W-1:0] w_th_c;
    logic signed [C_W-1:0] w_gx_c;
    logic signed [C_W-1:0] w_gy_c;
    logic signed [C_W-1:0] w_ax_c;
    logic signed [C_W-1:0] w_ay_c;
    logic signed [C_W-1:0] w_sum_c;
    logic                  w_x_edge;
    logic                  w_y_edge;

    assign w_gx_abs = r_s2_gx[G_W-1] ? $unsigned(-r_s2_gx) : $unsigned(r_s2_gx);
    assign w_gy_abs = r_s2_gy[G_W-1] ? $unsigned(-r_s2_gy) : $unsigned(r_s2_gy);
    assign w_sum    = {1'b0, w_gx_abs} + {1'b0, w_gy_abs};

    assign w_th_c  = {r_s2_th[TH_W-1], r_s2_th};
    assign w_gx_c  = {{(C_W-G_W){r_s2_gx[G_W-1]}}, r_s2_gx};
    assign w_gy_c  = {{(C_W-G_W){r_s2_gy[G_W-1]}}, r_s2_gy};
    assign w_ax_c  = {{(C_W-G_W){1'b0}}, w_gx_abs};
    assign w_ay_c  = {{(C_W-G_W){1'b0}}, w_gy_abs};
    assign w_sum_c = {{(C_W-S_W){1'b0}}, w_sum};

    always_comb begin
        w_x_edge = 1'b0;
        w_y_edge = 1'b0;
        case (r_s2_mode)
            2'd1: begin
                w_x_edge = w_ax_c > w_th_c;
                w_y_edge = w_ay_c > w_th_c;
            end
            2'd2: begin
                w_x_edge = w_sum_c > w_th_c;
                w_y_edge = w_sum_c > w_th_c;
            end
            default: begin   // mode 3 behaves as signed mode 0
                w_x_edge = w_gx_c > w_th_c;
                w_y_edge = w_gy_c > w_th_c;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
            o_out_x     <= '0;
            o_out_y     <= '0;
        end else begin
            o_out_valid <= r_s2_vld;
            o_out_last  <= r_s2_vld && r_s2_last;
            // edge maps hold their last value between results
            if (r_s2_vld) begin
                o_out_x <= w_x_edge ? 8'd255 : 8'd0;
                o_out_y <= w_y_edge ? 8'd255 : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on a 4x4 image (4 results per frame).
// Latency: results expected 3 cycles after the completing pixel; checked against a direct Sobel model.
// Backpressure: none in the DUT; the bench inserts random idle gaps.
module tb_sobel_stream;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_in_valid = 1'b0;
    logic [7:0]  i_in_pixel = '0;
    logic [19:0] i_threshold = '0;
    logic [1:0]  i_mode = '0;
    logic        o_out_valid;
    logic [7:0]  o_out_x;
    logic [7:0]  o_out_y;
    logic        o_out_last;

    sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H), .TH_W(20)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_in_valid (i_in_valid),
        .i_in_pixel (i_in_pixel),
        .i_threshold(i_threshold),
        .i_mode     (i_mode),
        .o_out_valid(o_out_valid),
        .o_out_x    (o_out_x),
        .o_out_y    (o_out_y),
        .o_out_last (o_out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        int         cyc;
        logic [7:0] x;
        logic [7:0] y;
        logic       last;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   img [0:H-1][0:W-1];
    int   total = 0;
    int   bad = 0;
    int   idle_bad = 0;
    bit   started = 0;
    logic [7:0] prev_x = '0;
    logic [7:0] prev_y = '0;

    // Records every result with its cycle, and notes idle cycles where the edge maps move or last is high.
    always @(negedge clk) begin
        if (i_reset) started = 1;
        if (started && !i_reset) begin
            if (o_out_valid)
                obs_q.push_back('{cyc: cyc, x: o_out_x, y: o_out_y, last: o_out_last});
            else if (o_out_last !== 1'b0 || o_out_x !== prev_x || o_out_y !== prev_y)
                idle_bad++;
        end
        prev_x = o_out_x;
        prev_y = o_out_y;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Sobel on the 3x3 neighbourhood whose bottom-right pixel is (r,c).
    function automatic res_t model(input int r, input int c, input int th, input int mode);
        res_t e;
        int gx, gy, ax, ay;
        bit ex, ey;
        gx = (img[r-2][c] - img[r-2][c-2]) + 2 * (img[r-1][c] - img[r-1][c-2]) + (img[r][c] - img[r][c-2]);
        gy = (img[r-2][c-2] - img[r][c-2]) + 2 * (img[r-2][c-1] - img[r][c-1]) + (img[r-2][c] - img[r][c]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mode)
            1:       begin ex = ax > th;          ey = ay > th;          end
            2:       begin ex = (ax + ay) > th;   ey = (ax + ay) > th;   end
            default: begin ex = gx > th;          ey = gy > th;          end
        endcase
        e.cyc  = 0;
        e.x    = ex ? 8'd255 : 8'd0;
        e.y    = ey ? 8'd255 : 8'd0;
        e.last = (r == H - 1) && (c == W - 1);
        return e;
    endfunction

    task automatic idle(input int n);
        i_in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Streams img as one frame; threshold/mode are only meaningful on pixel (0,0).
    task automatic send_frame(input int th, input int mode, input int maxgap, input bit scramble);
        res_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (maxgap > 0) begin
                    i_in_valid = 1'b0;
                    i_in_pixel = 8'($urandom);
                    idle($urandom_range(0, maxgap));
                end
                i_in_valid = 1'b1;
                i_in_pixel = 8'(img[r][c]);
                if ((r == 0 && c == 0) || !scramble) begin
                    i_threshold = th[19:0];
                    i_mode      = mode[1:0];
                end else begin
                    i_threshold = 20'($urandom);
                    i_mode      = 2'($urandom);
                end
                if (r >= 2 && c >= 2) begin
                    e = model(r, c, th, mode);
                    e.cyc = cyc + 3;
                    exp_q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
        end
        i_in_valid = 1'b0;
    endtask

    task automatic fill_cols(input int left, input int right);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = (c < 2) ? left : right;
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_out_valid); end
        total++; if (o_out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", o_out_last); end
        total++; if (o_out_x !== 8'd0) begin bad++; $display("FAIL reset_x got=%0d want=0", o_out_x); end
        total++; if (o_out_y !== 8'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", o_out_y); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flat();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 100;
        send_frame(0, 0, 0, 0);
        idle(6);
        total++; if (obs_q.size() != 4) begin bad++; $display("FAIL flat_count got=%0d want=4", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL flat_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_vertical();
        fill_cols(0, 255);
        send_frame(500, 0, 0, 0);
        idle(6);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL vert_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL vert_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // Mode/threshold are scrambled mid-frame to show they are only taken at (0,0).
    task automatic test_falling();
        fill_cols(255, 0);
        send_frame(500, 0, 0, 1);
        send_frame(500, 1, 0, 1);
        idle(6);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL fall_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL fall_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // |Gy|=800: th=700 fires, th=800 does not (strict greater-than).
    task automatic test_horizontal();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = (r < 2) ? 0 : 200;
        send_frame(700, 2, 0, 0);
        send_frame(800, 2, 0, 0);
        idle(6);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL horiz_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL horiz_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_gaps();
        fill_cols(0, 255);
        send_frame(500, 0, 5, 0);
        fill_cols(255, 0);
        send_frame(500, 0, 5, 0);
        idle(6);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL gaps_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL gaps_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        total++; if (idle_bad != 0) begin bad++; $display("FAIL gaps_hold got=%0d idle violations want=0", idle_bad); end
        obs_q.delete(); exp_q.delete();
    endtask

    // Frames abut with no gap; the previous frame's tail must keep its own threshold/mode.
    task automatic test_back_to_back();
        fill_cols(0, 255);
        send_frame(500, 0, 0, 0);
        fill_cols(255, 0);
        send_frame(-2000, 0, 0, 0);
        send_frame(5000, 1, 0, 0);
        idle(6);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        for (int f = 0; f < 12; f++) begin
            fill_random();
            send_frame(int'($urandom_range(0, 2200)) - 1100, int'($urandom_range(0, 3)), 2, 1);
        end
        idle(6);
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // Partial frame of 7 pixels, then reset; the next pixel must be treated as (0,0).
    task automatic test_reset_mid();
        fill_random();
        for (int k = 0; k < 7; k++) begin
            i_in_valid  = 1'b1;
            i_in_pixel  = 8'($urandom);
            i_threshold = 20'd0;
            i_mode      = 2'd0;
            @(posedge clk);
            #1;
        end
        i_in_valid = 1'b0;
        i_reset    = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        @(negedge clk);
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", o_out_valid); end
        @(posedge clk);
        #1;
        send_frame(300, 1, 1, 1);
        idle(6);
        total++; if (obs_q.size() != 4) begin bad++; $display("FAIL rstmid_count got=%0d want=4", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rstmid_res%0d got cyc=%0d x=%0d y=%0d last=%0d want cyc=%0d x=%0d y=%0d last=%0d", i, obs_q[i].cyc, obs_q[i].x, obs_q[i].y, obs_q[i].last, exp_q[i].cyc, exp_q[i].x, exp_q[i].y, exp_q[i].last); end
        end
        total++; if (idle_bad != 0) begin bad++; $display("FAIL idle_hold got=%0d idle violations want=0", idle_bad); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_flat();
        test_vertical();
        test_falling();
        test_horizontal();
        test_gaps();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
